// File: rtl/fc_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fc_l2_port_arbiter
// Purpose  : Shares one L2 TCDM master port among N_REQ TCDM-style requesters.
//            Round-robin selection with address-stability lock, zero-cycle
//            request path, in-order response routing through an ID FIFO that
//            also bounds the number of outstanding transactions.
// Ports    : clk_i/rst_i            clock, async active-high reset
//            req_i/add_i/wen_i/
//            wdata_i/be_i           flattened per-requester request buses
//            gnt_o                  per-requester grant
//            r_valid_o              per-requester response valid
//            r_rdata_o/r_opc_o      response data/error, broadcast
//            m_*_o / m_gnt_i        master request side
//            m_r_valid_i/m_r_*_i    master response side (in order)
//            protocol_err_o         sticky: response seen with no outstanding ID
//            grant_cnt_o/stall_cnt_o  per-requester 32-bit event counters
//                                   (only with FC_L2_ARB_PERF_CNT_EN defined)
// Options  : FC_L2_ARB_PERF_CNT_EN  enables the performance counters
// Revision : 1.0  initial release
// ============================================================================
module fc_l2_port_arbiter #(
  parameter int N_REQ           = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   add_i,
  input  logic [N_REQ-1:0]              wen_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   wdata_i,
  input  logic [N_REQ*DATA_WIDTH/8-1:0] be_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic [N_REQ-1:0]              r_valid_o,
  output logic [DATA_WIDTH-1:0]         r_rdata_o,
  output logic                          r_opc_o,
  output logic                          m_req_o,
  output logic [ADDR_WIDTH-1:0]         m_add_o,
  output logic                          m_wen_o,
  output logic [DATA_WIDTH-1:0]         m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]       m_be_o,
  input  logic                          m_gnt_i,
  input  logic                          m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]         m_r_rdata_i,
  input  logic                          m_r_opc_i,
`ifdef FC_L2_ARB_PERF_CNT_EN
  output logic [N_REQ*32-1:0]           grant_cnt_o,
  output logic [N_REQ*32-1:0]           stall_cnt_o,
`endif
  output logic                          protocol_err_o
);

  localparam int c_be_w  = DATA_WIDTH / 8;
  localparam int c_idx_w = $clog2(N_REQ);
  localparam int c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_cnt_w = $clog2(MAX_OUTSTANDING + 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_idx_w-1:0] r_rr_ptr;
  logic               r_locked;
  logic [c_idx_w-1:0] r_lock_idx;
  logic [c_idx_w-1:0] r_fifo [MAX_OUTSTANDING];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_protocol_err;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic [c_idx_w-1:0] w_rr_sel;
  logic               w_rr_found;
  logic [c_idx_w-1:0] w_sel;
  logic [c_idx_w-1:0] w_rr_next;
  logic [c_idx_w-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_hs;
  logic               w_pop;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    if (p == c_ptr_w'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + c_ptr_w'(1);
  endfunction

  // First requesting index at or after the round-robin pointer, with wrap.
  always_comb begin
    w_rr_sel   = r_rr_ptr;
    w_rr_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_rr_found && req_i[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_rr_sel   = c_idx_w'((int'(r_rr_ptr) + k) % N_REQ);
        w_rr_found = 1'b1;
      end
    end
  end

  // A pending (ungranted) request keeps its requester selected so the master
  // sees a stable address until the handshake completes.
  assign w_sel     = r_locked ? r_lock_idx : w_rr_sel;
  assign w_rr_next = (w_sel == c_idx_w'(N_REQ - 1)) ? '0 : w_sel + c_idx_w'(1);

  assign w_full  = (r_count == c_cnt_w'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  // Full is evaluated on the registered count only: a pop in the same cycle
  // does not free a slot until the next cycle.
  assign m_req_o   = (|req_i) & ~w_full & ~rst_i;
  assign w_hs      = m_req_o & m_gnt_i;
  assign w_pop     = m_r_valid_i & ~w_empty & ~rst_i;

  assign m_add_o   = add_i[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_wen_o   = wen_i[w_sel];
  assign m_wdata_o = wdata_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
  assign m_be_o    = be_i[int'(w_sel)*c_be_w +: c_be_w];

  always_comb begin
    gnt_o = '0;
    if (w_hs) begin
      gnt_o[w_sel] = 1'b1;
    end
  end

  always_comb begin
    r_valid_o = '0;
    if (w_pop) begin
      r_valid_o[w_head] = 1'b1;
    end
  end

  assign r_rdata_o      = m_r_rdata_i;
  assign r_opc_o        = m_r_opc_i;
  assign protocol_err_o = r_protocol_err;

  // --------------------------------------------------------------------------
  // Arbitration / FIFO control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr       <= '0;
      r_locked       <= 1'b0;
      r_lock_idx     <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_hs) begin
        r_rr_ptr <= w_rr_next;
        r_locked <= 1'b0;
      end else if (m_req_o) begin
        r_locked   <= 1'b1;
        r_lock_idx <= w_sel;
      end

      if (w_hs) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end

      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase

      if (m_r_valid_i && w_empty) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  // ID storage needs no reset: entries are only read when the count says valid.
  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      r_fifo[r_wr_ptr] <= w_sel;
    end
  end

`ifdef FC_L2_ARB_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_REQ; i++) begin : g_perf
    logic [31:0] r_grant_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_grant_cnt <= '0;
        r_stall_cnt <= '0;
      end else begin
        if (gnt_o[i]) begin
          r_grant_cnt <= r_grant_cnt + 32'd1;
        end
        if (req_i[i] && !gnt_o[i]) begin
          r_stall_cnt <= r_stall_cnt + 32'd1;
        end
      end
    end

    assign grant_cnt_o[i*32 +: 32] = r_grant_cnt;
    assign stall_cnt_o[i*32 +: 32] = r_stall_cnt;
  end
`endif

endmodule
`default_nettype wire
